// File: rtl/bin_to_bcd_framer_pkg.sv
// Shared constants for the binary-to-BCD framer: FSM codes, BCD limits
// and the leading-digit helper used when framing the result for the UART.
package bin_to_bcd_framer_pkg;

  typedef enum logic [1:0] {
    fsm_b2b_idle_p   = 2'b00,
    fsm_b2b_shift_p  = 2'b01,
    fsm_b2b_finish_p = 2'b10
  } b2b_state_t;

  localparam int bcd_max_value_p  = 9999;
  localparam int add3_threshold_p = 5;
  localparam int bcd_digits_p     = 4;

  // Index of the most significant non-zero digit; 0 for an all-zero value.
  function automatic logic [1:0] msd_index(input logic [4*bcd_digits_p-1:0] bcd);
    msd_index = '0;
    for (int d = 1; d < bcd_digits_p; d++)
      if (bcd[4*d +: 4] != 4'd0) msd_index = 2'(d);
  endfunction

endpackage

// File: rtl/bin_to_bcd_framer_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift the
// accumulator left one place taking the next binary bit into the units LSB.
module bcd_dabble_step
  import bin_to_bcd_framer_pkg::*;
#(
  parameter int digits_p = bcd_digits_p
) (
  input  logic [4*digits_p-1:0] acc,
  input  logic                  bit_in,
  output logic [4*digits_p-1:0] acc_next
);

  logic [digits_p-1:0][3:0] dig, adj;
  logic [4*digits_p-1:0]    adj_flat;

  assign dig = acc;

  for (genvar d = 0; d < digits_p; d++) begin : g_dig
    assign adj[d] = (dig[d] >= 4'(add3_threshold_p)) ? dig[d] + 4'd3 : dig[d];
  end

  assign adj_flat = adj;
  // Clamped input keeps the top bit zero, so dropping it loses nothing.
  assign acc_next = {adj_flat[4*digits_p-2:0], bit_in};

endmodule

// File: rtl/bin_to_bcd_framer.sv
// Sequential binary-to-BCD converter feeding the UART transmitter: one bit
// per clock, result and significant-digit index presented with a 1-cycle pulse.
module bin_to_bcd_framer
  import bin_to_bcd_framer_pkg::*;
#(
  parameter int bin_width_p = 16,
  parameter int digits_p    = bcd_digits_p,
  parameter int max_value_p = bcd_max_value_p
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic                   Start_i,
  input  logic [bin_width_p-1:0] Bin_i,
  input  logic                   Temp_LDR_i,
  output logic [4*digits_p-1:0]  Bcd_o,
  output logic [1:0]             Div_Stages_o,
  output logic                   Temp_LDR_o,
  output logic                   Data_available_o,
  output logic                   Busy_o,
  output logic                   Sat_o
);

  localparam int cnt_w_p = $clog2(bin_width_p + 1);
  localparam int bcd_w_p = 4 * digits_p;
  localparam logic [bin_width_p-1:0] max_bin_p = bin_width_p'(max_value_p);

  b2b_state_t               state_q, state_d;
  logic [bin_width_p-1:0]   bin_q;
  logic [bcd_w_p-1:0]       acc_q, acc_step;
  logic [cnt_w_p-1:0]       cnt_q;
  logic                     tl_q, sat_q;
  logic                     sat_in, last_iter;

  assign sat_in    = Bin_i > max_bin_p;
  assign last_iter = cnt_q == cnt_w_p'(bin_width_p - 1);

  bcd_dabble_step #(.digits_p(digits_p)) u_step (
    .acc      (acc_q),
    .bit_in   (bin_q[bin_width_p-1]),
    .acc_next (acc_step)
  );

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) state_q <= fsm_b2b_idle_p;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      fsm_b2b_idle_p:   if (Start_i) state_d = fsm_b2b_shift_p;
      fsm_b2b_shift_p:  if (last_iter) state_d = fsm_b2b_finish_p;
      fsm_b2b_finish_p: state_d = fsm_b2b_idle_p;
      default:          state_d = fsm_b2b_idle_p;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      bin_q            <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      tl_q             <= 1'b0;
      sat_q            <= 1'b0;
      Bcd_o            <= '0;
      Div_Stages_o     <= '0;
      Temp_LDR_o       <= 1'b0;
      Sat_o            <= 1'b0;
      Data_available_o <= 1'b0;
      Busy_o           <= 1'b0;
    end else begin
      case (state_q)
        fsm_b2b_idle_p: begin
          Data_available_o <= 1'b0;
          if (Start_i) begin
            bin_q  <= sat_in ? max_bin_p : Bin_i;
            acc_q  <= '0;
            cnt_q  <= '0;
            tl_q   <= Temp_LDR_i;
            sat_q  <= sat_in;
            Busy_o <= 1'b1;
          end
        end
        fsm_b2b_shift_p: begin
          acc_q <= acc_step;
          bin_q <= {bin_q[bin_width_p-2:0], 1'b0};
          cnt_q <= cnt_q + cnt_w_p'(1);
        end
        fsm_b2b_finish_p: begin
          Bcd_o            <= acc_q;
          Div_Stages_o     <= msd_index(acc_q);
          Temp_LDR_o       <= tl_q;
          Sat_o            <= sat_q;
          Data_available_o <= 1'b1;
          Busy_o           <= 1'b0;
        end
        default: begin
          bin_q            <= '0;
          acc_q            <= '0;
          cnt_q            <= '0;
          tl_q             <= 1'b0;
          sat_q            <= 1'b0;
          Bcd_o            <= '0;
          Div_Stages_o     <= '0;
          Temp_LDR_o       <= 1'b0;
          Sat_o            <= 1'b0;
          Data_available_o <= 1'b0;
          Busy_o           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_framer.sv
// Bench for bin_to_bcd_framer: decimal reference model checked every cycle,
// directed literal cases, a strided value sweep and randomized traffic.
module tb_bin_to_bcd_framer;

  logic        Clk_i = 1'b0;
  logic        Reset_i, Start_i, Temp_LDR_i;
  logic [15:0] Bin_i;
  logic [15:0] Bcd_o;
  logic [1:0]  Div_Stages_o;
  logic        Temp_LDR_o, Data_available_o, Busy_o, Sat_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: cycles left until the pulse, pending and presented results
  int          m_remain = 0;
  logic        m_dav = 0, m_tl = 0, m_sat = 0, p_tl = 0, p_sat = 0;
  logic [15:0] m_bcd = 0, p_bcd = 0;
  logic [1:0]  m_div = 0, p_div = 0;

  bin_to_bcd_framer dut (
    .Clk_i            (Clk_i),
    .Reset_i          (Reset_i),
    .Start_i          (Start_i),
    .Bin_i            (Bin_i),
    .Temp_LDR_i       (Temp_LDR_i),
    .Bcd_o            (Bcd_o),
    .Div_Stages_o     (Div_Stages_o),
    .Temp_LDR_o       (Temp_LDR_o),
    .Data_available_o (Data_available_o),
    .Busy_o           (Busy_o),
    .Sat_o            (Sat_o)
  );

  always #5 Clk_i = ~Clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [1:0] ref_div(input int v);
    return (v >= 1000) ? 2'd3 : (v >= 100) ? 2'd2 : (v >= 10) ? 2'd1 : 2'd0;
  endfunction

  task automatic model_step();
    int v;
    if (!Reset_i) begin
      m_remain = 0; m_dav = 0; m_bcd = 0; m_div = 0; m_tl = 0; m_sat = 0;
    end else begin
      m_dav = 0;
      if (m_remain > 0) begin
        m_remain--;
        if (m_remain == 0) begin
          m_dav = 1; m_bcd = p_bcd; m_div = p_div; m_tl = p_tl; m_sat = p_sat;
        end
      end else if (Start_i) begin
        v = int'(Bin_i);
        p_sat = v > 9999;
        if (p_sat) v = 9999;
        p_bcd = ref_bcd(v);
        p_div = ref_div(v);
        p_tl  = Temp_LDR_i;
        m_remain = 17;
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clk_i);
    model_step();
    #1;
    chk("dav",  32'(Data_available_o), 32'(m_dav));
    chk("busy", 32'(Busy_o),           32'(m_remain != 0));
    chk("bcd",  32'(Bcd_o),            32'(m_bcd));
    chk("div",  32'(Div_Stages_o),     32'(m_div));
    chk("tl",   32'(Temp_LDR_o),       32'(m_tl));
    chk("sat",  32'(Sat_o),            32'(m_sat));
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (!Data_available_o && n < 40) begin cyc(); n++; end
    chk("pulse_seen", 32'(Data_available_o), 32'd1);
  endtask

  task automatic conv(input logic [15:0] v, input logic t, input logic lit,
                      input logic [15:0] eb, input logic [1:0] ed, input logic es);
    int n;
    Start_i = 1; Bin_i = v; Temp_LDR_i = t;
    cyc();
    Start_i = 0; Bin_i = 16'($urandom); Temp_LDR_i = 1'($urandom);
    wait_pulse(n);
    chk("latency", 32'(n), 32'd17);
    if (lit) begin
      chk("lit_bcd", 32'(Bcd_o),        32'(eb));
      chk("lit_div", 32'(Div_Stages_o), 32'(ed));
      chk("lit_sat", 32'(Sat_o),        32'(es));
      chk("lit_tl",  32'(Temp_LDR_o),   32'(t));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset_i = 0; Start_i = 0; Bin_i = 0; Temp_LDR_i = 0;
    repeat (3) cyc();
    Reset_i = 1;
    cyc();
    chk("rst_bcd",  32'(Bcd_o),            32'd0);
    chk("rst_div",  32'(Div_Stages_o),     32'd0);
    chk("rst_dav",  32'(Data_available_o), 32'd0);
    chk("rst_busy", 32'(Busy_o),           32'd0);

    conv(16'd0,     1'b1, 1'b1, 16'h0000, 2'd0, 1'b0);
    cyc();
    chk("pulse_one_cycle", 32'(Data_available_o), 32'd0);
    chk("hold_tl",         32'(Temp_LDR_o),       32'd1);
    conv(16'd1234,  1'b0, 1'b1, 16'h1234, 2'd3, 1'b0);
    conv(16'd305,   1'b1, 1'b1, 16'h0305, 2'd2, 1'b0);
    conv(16'd7,     1'b0, 1'b1, 16'h0007, 2'd0, 1'b0);
    conv(16'd40,    1'b1, 1'b1, 16'h0040, 2'd1, 1'b0);
    conv(16'hFFFF,  1'b0, 1'b1, 16'h9999, 2'd3, 1'b1);
    conv(16'd10000, 1'b1, 1'b1, 16'h9999, 2'd3, 1'b1);
    conv(16'd9999,  1'b0, 1'b1, 16'h9999, 2'd3, 1'b0);
    repeat (3) cyc();

    // Start during conversion is dropped; Start right after the pulse is taken.
    Start_i = 1; Bin_i = 16'd1234; Temp_LDR_i = 1; cyc();
    Start_i = 0; repeat (4) cyc();
    Start_i = 1; Bin_i = 16'd55; cyc();
    Start_i = 0;
    wait_pulse(n);
    chk("ign_bcd", 32'(Bcd_o), 32'h1234);
    conv(16'd55, 1'b0, 1'b1, 16'h0055, 2'd1, 1'b0);
    repeat (20) cyc();

    // Reset mid-conversion aborts without a pulse.
    Start_i = 1; Bin_i = 16'd4321; Temp_LDR_i = 1; cyc();
    Start_i = 0; repeat (7) cyc();
    Reset_i = 0; cyc();
    Reset_i = 1;
    chk("abort_busy", 32'(Busy_o),           32'd0);
    chk("abort_bcd",  32'(Bcd_o),            32'd0);
    chk("abort_dav",  32'(Data_available_o), 32'd0);
    chk("abort_tl",   32'(Temp_LDR_o),       32'd0);
    repeat (20) cyc();
    conv(16'd4321, 1'b1, 1'b1, 16'h4321, 2'd3, 1'b0);

    for (int v = 0; v < 10000; v += 7) begin
      conv(16'(v), 1'($urandom), 1'b0, 16'h0, 2'd0, 1'b0);
      repeat ($urandom_range(0, 2)) cyc();
    end

    for (int i = 0; i < 20000; i++) begin
      Reset_i    = ($urandom_range(0, 999) != 0);
      Start_i    = ($urandom_range(0, 5) == 0);
      Temp_LDR_i = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       Bin_i = 16'($urandom);
        1:       Bin_i = 16'($urandom_range(0, 9999));
        2:       Bin_i = 16'($urandom_range(9990, 10010));
        default: Bin_i = 16'($urandom_range(0, 120));
      endcase
      cyc();
    end
    Reset_i = 1; Start_i = 0;
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
